edp_slice_n: RTL and testbench

- Parametrised execution-data-path slice: W-bit slice of AR, ARX, BR, BRX and MQ registers, a boolean/arithmetic adder with group carry outputs, and a fast-memory (FM) AC array with parity.
- Registered EBUS/diagnostic readback; sticky FM parity error.
- Successor to the fixed 6-bit EDP board slice. Slices are abutted by wiring cry_in/cg/cp and shift-in/out bits between neighbours.

---
 rtl/edp_pkg.sv | 33 +++
 rtl/edp_fm.sv | 58 +++++
 rtl/edp_slice_n.sv | 196 +++++++++++++++++++
 tb/tb_edp_slice_n.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edp_pkg.sv
// Shared selector encodings, adder function codes and FM parity helper for
// the EDP slice.
package edp_pkg;

  typedef enum logic [1:0] {AR_AD, AR_CACHE, AR_SH, AR_FM}          ar_sel_e;
  typedef enum logic [1:0] {ARX_AD, ARX_CACHE, ARX_SH, ARX_MQ}      arx_sel_e;
  typedef enum logic [1:0] {MQ_HOLD, MQ_LOAD, MQ_SHL, MQ_SHR}       mq_sel_e;
  typedef enum logic [1:0] {MQM_AD, MQM_SH, MQM_CACHE, MQM_ZERO}    mqm_sel_e;
  typedef enum logic [1:0] {ADA_AR, ADA_ARX, ADA_MQ, ADA_PC}        ada_sel_e;
  typedef enum logic [1:0] {ADB_FM, ADB_BR, ADB_BRX, ADB_ONES}      adb_sel_e;
  typedef enum logic [2:0] {DIAG_AR, DIAG_ARX, DIAG_BR, DIAG_BRX,
                            DIAG_MQ, DIAG_FM, DIAG_AD, DIAG_ZERO}   diag_sel_e;

  // Arithmetic codes: [3:2] picks X, [1:0] picks Y; subtract needs cin = 1.
  localparam logic [3:0] AD_A          = 4'h0;
  localparam logic [3:0] AD_A_PLUS_B   = 4'h1;
  localparam logic [3:0] AD_A_MINUS_B  = 4'h2;
  localparam logic [3:0] AD_A_MINUS_1  = 4'h3;
  localparam logic [3:0] AD_AND_PLUS_B = 4'h5;
  localparam logic [3:0] AD_OR_PLUS_1S = 4'hF;
  // Boolean codes: result bit = ad_func[{a,b}].
  localparam logic [3:0] AD_BOOL_ZERO  = 4'h0;
  localparam logic [3:0] AD_BOOL_XOR   = 4'h6;
  localparam logic [3:0] AD_BOOL_AND   = 4'h8;
  localparam logic [3:0] AD_BOOL_B     = 4'hA;
  localparam logic [3:0] AD_BOOL_A     = 4'hC;
  localparam logic [3:0] AD_BOOL_OR    = 4'hE;

  function automatic logic parity_bit(input logic [35:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/edp_fm.sv
// Fast-memory AC array: asynchronous read, stored parity per word, and a
// sticky parity error that survives until cleared or reset.
module edp_fm
  import edp_pkg::*;
#(
  parameter int W         = 6,
  parameter int FM_BLOCKS = 8,
  parameter int FM_ACS    = 16,
  parameter int PAR_ODD   = 1,
  localparam int BW = (FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1,
  localparam int AW = (FM_ACS > 1) ? $clog2(FM_ACS) : 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic [BW-1:0] blk,
  input  logic [AW-1:0] adr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          check,
  input  logic          err_clr,
  output logic [W-1:0]  rd_data,
  output logic          rd_par,
  output logic          par_err
);

  localparam int DEPTH = FM_BLOCKS * FM_ACS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W:0]    fm_mem [DEPTH];
  logic [IW-1:0] idx;
  logic          in_range;
  logic [W:0]    rd_word;
  logic          par_bad;

  assign idx      = IW'(blk) * IW'(FM_ACS) + IW'(adr);
  assign in_range = (int'(blk) < FM_BLOCKS) && (int'(adr) < FM_ACS);
  assign rd_word  = in_range ? fm_mem[idx] : '0;
  assign rd_data  = rd_word[W:1];
  assign rd_par   = rd_word[0];
  assign par_bad  = rd_word[0] != parity_bit(36'(rd_word[W:1]), PAR_ODD != 0);

  // Contents are deliberately not reset so they survive a slice reset.
  always_ff @(posedge clk) begin
    if (wr_en && in_range)
      fm_mem[idx] <= {wr_data, parity_bit(36'(wr_data), PAR_ODD != 0)};
  end

  // Set has priority over clear so a fresh error is never lost.
  always_ff @(posedge clk) begin
    if (!rst_l)
      par_err <= 1'b0;
    else if (check && in_range && par_bad)
      par_err <= 1'b1;
    else if (err_clr)
      par_err <= 1'b0;
  end

endmodule

// File: rtl/edp_slice_n.sv
// W-bit execution data-path slice: AR/ARX/BR/BRX/MQ, boolean/arithmetic adder
// with group carry terms, FM array and registered EBUS/diagnostic readback.
module edp_slice_n
  import edp_pkg::*;
#(
  parameter int W         = 6,
  parameter int FM_BLOCKS = 8,
  parameter int FM_ACS    = 16,
  parameter int PAR_ODD   = 1,
  localparam int BW = (FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1,
  localparam int AW = (FM_ACS > 1) ? $clog2(FM_ACS) : 1
) (
  input  logic          clk_edp_h,
  input  logic          edp_reset_l,
  input  logic [1:0]    ar_sel,
  input  logic          ar_load_h,
  input  logic          arx_load_h,
  input  logic          br_load_h,
  input  logic          brx_load_h,
  input  logic [1:0]    arx_sel,
  input  logic [1:0]    mq_sel,
  input  logic [1:0]    mqm_sel,
  input  logic          mq_shin_lo_h,
  input  logic          mq_shin_hi_h,
  output logic          mq_shout_hi_h,
  output logic          mq_shout_lo_h,
  input  logic [W-1:0]  cache_data_h,
  input  logic [W-1:0]  sh_h,
  input  logic [W-1:0]  vma_held_or_pc_h,
  input  logic [1:0]    ada_sel,
  input  logic          ada_dis_h,
  input  logic [1:0]    adb_sel,
  input  logic          ad_boole_h,
  input  logic [3:0]    ad_func,
  input  logic          ad_cry_in_h,
  output logic [W-1:0]  ad_h,
  output logic          ad_cry_out_h,
  output logic          ad_cg_h,
  output logic          ad_cp_h,
  output logic          ad_ovf_h,
  output logic          ad_eq0_h,
  output logic [W-1:0]  ar_h,
  output logic [W-1:0]  arx_h,
  output logic [W-1:0]  br_h,
  output logic [W-1:0]  brx_h,
  output logic [W-1:0]  mq_h,
  input  logic [BW-1:0] fm_block,
  input  logic [AW-1:0] fm_adr,
  input  logic          fm_write_l,
  input  logic          fm_check_h,
  input  logic          fm_err_clr_h,
  output logic          fm_par_err_h,
  output logic          fm_parity_h,
  input  logic          ebus_drive_h,
  input  logic          diag_read_h,
  input  logic [2:0]    diag_sel,
  output logic [W-1:0]  ebus_d_h
);

  logic [W-1:0] ar, arx, br, brx, mq, ebus_p1;
  logic [W-1:0] fm_rd, ada, adb, x_op, y_op, bool_f, ad;
  logic [W-1:0] arm, arxm, mqm, diag;
  logic [W:0]   gen_full, sum_full;
  logic         msb_cin;

  edp_fm #(
    .W(W), .FM_BLOCKS(FM_BLOCKS), .FM_ACS(FM_ACS), .PAR_ODD(PAR_ODD)
  ) u_fm (
    .clk     (clk_edp_h),
    .rst_l   (edp_reset_l),
    .blk     (fm_block),
    .adr     (fm_adr),
    .wr_en   (!fm_write_l),
    .wr_data (ar),
    .check   (fm_check_h),
    .err_clr (fm_err_clr_h),
    .rd_data (fm_rd),
    .rd_par  (fm_parity_h),
    .par_err (fm_par_err_h)
  );

  always_comb begin
    ada = '0;
    if (!ada_dis_h) begin
      case (ada_sel_e'(ada_sel))
        ADA_AR:  ada = ar;
        ADA_ARX: ada = arx;
        ADA_MQ:  ada = mq;
        ADA_PC:  ada = vma_held_or_pc_h;
        default: ada = '0;
      endcase
    end
    case (adb_sel_e'(adb_sel))
      ADB_FM:  adb = fm_rd;
      ADB_BR:  adb = br;
      ADB_BRX: adb = brx;
      default: adb = '1;
    endcase
  end

  always_comb begin
    case (ad_func[3:2])
      2'd0:    x_op = ada;
      2'd1:    x_op = ada & adb;
      2'd2:    x_op = ada & ~adb;
      default: x_op = ada | adb;
    endcase
    case (ad_func[1:0])
      2'd0:    y_op = '0;
      2'd1:    y_op = adb;
      2'd2:    y_op = ~adb;
      default: y_op = '1;
    endcase
    bool_f = '0;
    for (int i = 0; i < W; i++)
      bool_f[i] = ad_func[{ada[i], adb[i]}];
  end

  // Generate is the carry with cin held at 0; the cin add cannot overflow W+1 bits.
  assign gen_full = {1'b0, x_op} + {1'b0, y_op};
  assign sum_full = gen_full + {{W{1'b0}}, ad_cry_in_h};
  assign msb_cin  = x_op[W-1] ^ y_op[W-1] ^ sum_full[W-1];

  assign ad           = ad_boole_h ? bool_f : sum_full[W-1:0];
  assign ad_h         = ad;
  assign ad_cry_out_h = !ad_boole_h && sum_full[W];
  assign ad_cg_h      = !ad_boole_h && gen_full[W];
  assign ad_cp_h      = !ad_boole_h && (&(x_op ^ y_op));
  assign ad_ovf_h     = !ad_boole_h && (msb_cin ^ sum_full[W]);
  assign ad_eq0_h     = (ad == '0);

  always_comb begin
    case (ar_sel_e'(ar_sel))
      AR_AD:    arm = ad;
      AR_CACHE: arm = cache_data_h;
      AR_SH:    arm = sh_h;
      default:  arm = fm_rd;
    endcase
    case (arx_sel_e'(arx_sel))
      ARX_AD:    arxm = ad;
      ARX_CACHE: arxm = cache_data_h;
      ARX_SH:    arxm = sh_h;
      default:   arxm = mq;
    endcase
    case (mqm_sel_e'(mqm_sel))
      MQM_AD:    mqm = ad;
      MQM_SH:    mqm = sh_h;
      MQM_CACHE: mqm = cache_data_h;
      default:   mqm = '0;
    endcase
    case (diag_sel_e'(diag_sel))
      DIAG_AR:  diag = ar;
      DIAG_ARX: diag = arx;
      DIAG_BR:  diag = br;
      DIAG_BRX: diag = brx;
      DIAG_MQ:  diag = mq;
      DIAG_FM:  diag = fm_rd;
      DIAG_AD:  diag = ad;
      default:  diag = '0;
    endcase
  end

  // Register stage: every source sees pre-edge values, so AR := f(AR) is safe.
  always_ff @(posedge clk_edp_h) begin
    if (!edp_reset_l) begin
      ar      <= '0;
      arx     <= '0;
      br      <= '0;
      brx     <= '0;
      mq      <= '0;
      ebus_p1 <= '0;
    end else begin
      if (ar_load_h)  ar  <= arm;
      if (arx_load_h) arx <= arxm;
      if (br_load_h)  br  <= ar;
      if (brx_load_h) brx <= arx;
      case (mq_sel_e'(mq_sel))
        MQ_LOAD: mq <= mqm;
        MQ_SHL:  mq <= {mq[W-2:0], mq_shin_lo_h};
        MQ_SHR:  mq <= {mq_shin_hi_h, mq[W-1:1]};
        default: mq <= mq;
      endcase
      ebus_p1 <= ebus_drive_h ? (diag_read_h ? diag : ad) : '0;
    end
  end

  assign ar_h          = ar;
  assign arx_h         = arx;
  assign br_h          = br;
  assign brx_h         = brx;
  assign mq_h          = mq;
  assign ebus_d_h      = ebus_p1;
  assign mq_shout_hi_h = mq[W-1];
  assign mq_shout_lo_h = mq[0];

endmodule

// File: tb/tb_edp_slice_n.sv
// Bench for edp_slice_n at W=6: adder vector table, directed multi-cycle
// sequences, then randomized cycles against a behavioural model.
module tb_edp_slice_n;
  import edp_pkg::*;

  localparam int W = 6, FM_BLOCKS = 8, FM_ACS = 16, PAR_ODD = 1;
  localparam int MASK = (1 << W) - 1;
  localparam int DEPTH = FM_BLOCKS * FM_ACS;

  logic clk = 1'b0;
  logic edp_reset_l;
  logic [1:0] ar_sel, arx_sel, mq_sel, mqm_sel, ada_sel, adb_sel;
  logic ar_load_h, arx_load_h, br_load_h, brx_load_h;
  logic mq_shin_lo_h, mq_shin_hi_h, mq_shout_hi_h, mq_shout_lo_h;
  logic [W-1:0] cache_data_h, sh_h, vma_held_or_pc_h;
  logic ada_dis_h, ad_boole_h, ad_cry_in_h;
  logic [3:0] ad_func;
  logic [W-1:0] ad_h, ar_h, arx_h, br_h, brx_h, mq_h, ebus_d_h;
  logic ad_cry_out_h, ad_cg_h, ad_cp_h, ad_ovf_h, ad_eq0_h;
  logic [2:0] fm_block;
  logic [3:0] fm_adr;
  logic fm_write_l, fm_check_h, fm_err_clr_h, fm_par_err_h, fm_parity_h;
  logic ebus_drive_h, diag_read_h;
  logic [2:0] diag_sel;

  edp_slice_n #(.W(W), .FM_BLOCKS(FM_BLOCKS), .FM_ACS(FM_ACS), .PAR_ODD(PAR_ODD)) dut (
    .clk_edp_h(clk), .edp_reset_l(edp_reset_l),
    .ar_sel(ar_sel), .ar_load_h(ar_load_h), .arx_load_h(arx_load_h),
    .br_load_h(br_load_h), .brx_load_h(brx_load_h), .arx_sel(arx_sel),
    .mq_sel(mq_sel), .mqm_sel(mqm_sel), .mq_shin_lo_h(mq_shin_lo_h),
    .mq_shin_hi_h(mq_shin_hi_h), .mq_shout_hi_h(mq_shout_hi_h), .mq_shout_lo_h(mq_shout_lo_h),
    .cache_data_h(cache_data_h), .sh_h(sh_h), .vma_held_or_pc_h(vma_held_or_pc_h),
    .ada_sel(ada_sel), .ada_dis_h(ada_dis_h), .adb_sel(adb_sel), .ad_boole_h(ad_boole_h),
    .ad_func(ad_func), .ad_cry_in_h(ad_cry_in_h), .ad_h(ad_h), .ad_cry_out_h(ad_cry_out_h),
    .ad_cg_h(ad_cg_h), .ad_cp_h(ad_cp_h), .ad_ovf_h(ad_ovf_h), .ad_eq0_h(ad_eq0_h),
    .ar_h(ar_h), .arx_h(arx_h), .br_h(br_h), .brx_h(brx_h), .mq_h(mq_h),
    .fm_block(fm_block), .fm_adr(fm_adr), .fm_write_l(fm_write_l), .fm_check_h(fm_check_h),
    .fm_err_clr_h(fm_err_clr_h), .fm_par_err_h(fm_par_err_h), .fm_parity_h(fm_parity_h),
    .ebus_drive_h(ebus_drive_h), .diag_read_h(diag_read_h), .diag_sel(diag_sel),
    .ebus_d_h(ebus_d_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       boole;
    logic [3:0] func;
    logic       cin;
    logic [5:0] a, b, ad;
    logic       cry, cg, cp, ovf, eq0;
  } ad_vec_t;

  ad_vec_t tv [11];
  int n_vec = 0, n_err = 0;

  // Model state
  int m_ar, m_arx, m_br, m_brx, m_mq, m_ebus, m_err;
  int fm_d [DEPTH];
  int fm_p [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    edp_reset_l = 1'b1; ar_sel = 2'd0; arx_sel = 2'd0; mq_sel = 2'd0; mqm_sel = 2'd0;
    ar_load_h = 1'b0; arx_load_h = 1'b0; br_load_h = 1'b0; brx_load_h = 1'b0;
    mq_shin_lo_h = 1'b0; mq_shin_hi_h = 1'b0; cache_data_h = '0; sh_h = '0;
    vma_held_or_pc_h = '0; ada_sel = 2'd0; ada_dis_h = 1'b0; adb_sel = 2'd1;
    ad_boole_h = 1'b0; ad_func = 4'h0; ad_cry_in_h = 1'b0; fm_block = '0; fm_adr = '0;
    fm_write_l = 1'b1; fm_check_h = 1'b0; fm_err_clr_h = 1'b0;
    ebus_drive_h = 1'b0; diag_read_h = 1'b0; diag_sel = 3'd0;
  endtask

  task automatic set_ar(input logic [W-1:0] v);
    ar_sel = AR_CACHE; cache_data_h = v; ar_load_h = 1'b1;
    tick();
    ar_load_h = 1'b0;
  endtask

  task automatic set_br(input logic [W-1:0] v);
    set_ar(v);
    br_load_h = 1'b1;
    tick();
    br_load_h = 1'b0;
  endtask

  task automatic set_brx(input logic [W-1:0] v);
    arx_sel = ARX_CACHE; cache_data_h = v; arx_load_h = 1'b1;
    tick();
    arx_load_h = 1'b0; brx_load_h = 1'b1;
    tick();
    brx_load_h = 1'b0;
  endtask

  task automatic set_mq(input logic [W-1:0] v);
    mq_sel = MQ_LOAD; mqm_sel = MQM_CACHE; cache_data_h = v;
    tick();
    mq_sel = MQ_HOLD;
  endtask

  // AD = 0 + FM word, exposing the asynchronous FM read
  task automatic ad_shows_fm();
    ada_dis_h = 1'b1; adb_sel = ADB_FM; ad_boole_h = 1'b0;
    ad_func = AD_A_PLUS_B; ad_cry_in_h = 1'b0;
  endtask

  function automatic int par_of(input int d);
    int ones;
    ones = $countones(d & MASK);
    return (PAR_ODD != 0) ? ((ones % 2 == 0) ? 1 : 0) : ((ones % 2 == 1) ? 1 : 0);
  endfunction

  function automatic void ref_adder(input int a, input int b, input bit boole, input int func,
                                    input bit cin, output int r, output bit cry, output bit cg,
                                    output bit cp, output bit ovf);
    int x, y, s;
    r = 0; cry = 0; cg = 0; cp = 0; ovf = 0;
    if (boole) begin
      for (int i = 0; i < W; i++)
        if (((func >> (((a >> i) & 1) * 2 + ((b >> i) & 1))) & 1) == 1) r |= (1 << i);
      return;
    end
    case (func >> 2)
      0: x = a;
      1: x = a & b;
      2: x = a & ~b & MASK;
      default: x = a | b;
    endcase
    case (func & 3)
      0: y = 0;
      1: y = b;
      2: y = ~b & MASK;
      default: y = MASK;
    endcase
    s   = x + y + int'(cin);
    r   = s & MASK;
    cry = ((s >> W) & 1) == 1;
    cg  = (((x + y) >> W) & 1) == 1;
    cp  = (x ^ y) == MASK;
    ovf = (((((x & (MASK >> 1)) + (y & (MASK >> 1)) + int'(cin)) >> (W - 1)) & 1) == 1) ^ cry;
  endfunction

  task automatic reset_dut();
    idle();
    edp_reset_l = 1'b0;
    tick();
    edp_reset_l = 1'b1;
  endtask

  // Fill every FM word with a known random value and record it in the model
  task automatic fm_sweep();
    int v;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      v = int'($urandom) & MASK;
      set_ar(W'(v));
      fm_block = 3'(i / FM_ACS); fm_adr = 4'(i % FM_ACS); fm_write_l = 1'b0;
      tick();
      fm_write_l = 1'b1;
      fm_d[i] = v;
      fm_p[i] = par_of(v);
    end
  endtask

  initial begin
    int r, idx, rd, a, b, dg, n_ar, n_arx, n_br, n_brx, n_mq, n_ebus, n_err_m;
    bit cy, g, p, o;

    tv[0]  = '{1'b0, AD_A_PLUS_B,   1'b0, 6'h3F, 6'h01, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b0, AD_A_PLUS_B,   1'b0, 6'h1F, 6'h01, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, AD_A_MINUS_B,  1'b1, 6'h05, 6'h07, 6'h3E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, AD_BOOL_XOR,   1'b0, 6'h35, 6'h0F, 6'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, AD_BOOL_AND,   1'b0, 6'h35, 6'h0F, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, AD_BOOL_OR,    1'b1, 6'h35, 6'h0F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b0, AD_A,          1'b0, 6'h2A, 6'h11, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, AD_A_MINUS_1,  1'b0, 6'h00, 6'h11, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b0, AD_A_PLUS_B,   1'b1, 6'h2A, 6'h15, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b0, AD_OR_PLUS_1S, 1'b0, 6'h10, 6'h01, 6'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b0, AD_A_MINUS_B,  1'b1, 6'h07, 6'h05, 6'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state and reset dominance
    idle();
    edp_reset_l = 1'b0;
    tick(); tick();
    edp_reset_l = 1'b1;
    chk("rst_ar", ar_h, 0);   chk("rst_arx", arx_h, 0); chk("rst_br", br_h, 0);
    chk("rst_brx", brx_h, 0); chk("rst_mq", mq_h, 0);   chk("rst_ebus", ebus_d_h, 0);
    chk("rst_err", fm_par_err_h, 0);

    set_br(6'h2A); set_brx(6'h2A); set_mq(6'h2A);
    fm_block = 3'd1; fm_adr = 4'd2; fm_write_l = 1'b0;
    tick();
    fm_write_l = 1'b1;
    ebus_drive_h = 1'b1; diag_read_h = 1'b1; diag_sel = DIAG_AR;
    tick();
    chk("pre_rst_ar", ar_h, 6'h2A); chk("pre_rst_brx", brx_h, 6'h2A);
    chk("pre_rst_ebus", ebus_d_h, 6'h2A);
    edp_reset_l = 1'b0; ar_load_h = 1'b1; cache_data_h = 6'h11; mq_sel = MQ_LOAD;
    tick();
    idle();
    chk("rst2_ar", ar_h, 0);   chk("rst2_arx", arx_h, 0); chk("rst2_br", br_h, 0);
    chk("rst2_brx", brx_h, 0); chk("rst2_mq", mq_h, 0);   chk("rst2_ebus", ebus_d_h, 0);
    chk("rst2_err", fm_par_err_h, 0);
    fm_block = 3'd1; fm_adr = 4'd2; ad_shows_fm();
    #1;
    chk("rst_fm_kept", ad_h, 6'h2A); chk("rst_fm_par", fm_parity_h, 0);

    // Adder vector table
    for (int i = 0; i < 11; i++) begin
      idle();
      set_br(tv[i].b);
      set_ar(tv[i].a);
      ada_sel = ADA_AR; adb_sel = ADB_BR;
      ad_boole_h = tv[i].boole; ad_func = tv[i].func; ad_cry_in_h = tv[i].cin;
      #1;
      chk($sformatf("tv%0d_ad", i), ad_h, tv[i].ad);
      chk($sformatf("tv%0d_cry", i), ad_cry_out_h, tv[i].cry);
      chk($sformatf("tv%0d_cg", i), ad_cg_h, tv[i].cg);
      chk($sformatf("tv%0d_cp", i), ad_cp_h, tv[i].cp);
      chk($sformatf("tv%0d_ovf", i), ad_ovf_h, tv[i].ovf);
      chk($sformatf("tv%0d_eq0", i), ad_eq0_h, tv[i].eq0);
    end

    // MQ shifts
    idle();
    set_mq(6'h21);
    chk("mq_shout_hi", mq_shout_hi_h, 1); chk("mq_shout_lo", mq_shout_lo_h, 1);
    mq_sel = MQ_SHL; mq_shin_lo_h = 1'b1;
    tick();
    chk("mq_shl", mq_h, 6'h03);
    mq_sel = MQ_SHR; mq_shin_lo_h = 1'b0; mq_shin_hi_h = 1'b1;
    tick();
    mq_sel = MQ_HOLD;
    chk("mq_shr", mq_h, 6'h21);

    // FM write-through-read ordering and sticky parity error
    idle();
    set_ar(6'h0A);
    fm_block = 3'd3; fm_adr = 4'd7; fm_write_l = 1'b0;
    tick();
    fm_write_l = 1'b1;
    set_ar(6'h15);
    fm_write_l = 1'b0; ad_shows_fm();
    #1;
    chk("fm_old_read", ad_h, 6'h0A);
    tick();
    fm_write_l = 1'b1;
    #1;
    chk("fm_new_read", ad_h, 6'h15); chk("fm_new_par", fm_parity_h, 0);
    fm_check_h = 1'b1;
    tick();
    chk("fm_no_err", fm_par_err_h, 0);
    dut.u_fm.fm_mem[3 * FM_ACS + 7] <= 7'h2B;
    tick();
    chk("fm_err_set", fm_par_err_h, 1);
    fm_check_h = 1'b0;
    tick();
    chk("fm_err_hold", fm_par_err_h, 1);
    fm_check_h = 1'b1; fm_err_clr_h = 1'b1;
    tick();
    chk("fm_set_beats_clr", fm_par_err_h, 1);
    fm_check_h = 1'b0;
    tick();
    fm_err_clr_h = 1'b0;
    chk("fm_err_clr", fm_par_err_h, 0);

    // EBUS readback
    idle();
    set_mq(6'h2C);
    ebus_drive_h = 1'b1; diag_read_h = 1'b1; diag_sel = DIAG_MQ;
    tick();
    chk("ebus_diag_mq", ebus_d_h, 6'h2C);
    diag_read_h = 1'b0; ada_sel = ADA_MQ; ad_func = AD_A; ad_boole_h = 1'b0;
    tick();
    chk("ebus_ad", ebus_d_h, 6'h2C);
    ebus_drive_h = 1'b0;
    tick();
    chk("ebus_off", ebus_d_h, 0);

    // Randomized cycles against the model
    reset_dut();
    fm_sweep();
    reset_dut();
    m_ar = 0; m_arx = 0; m_br = 0; m_brx = 0; m_mq = 0; m_ebus = 0; m_err = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      edp_reset_l = ($urandom_range(0, 49) != 0);
      ar_sel = 2'($urandom); arx_sel = 2'($urandom); mq_sel = 2'($urandom); mqm_sel = 2'($urandom);
      ar_load_h = 1'($urandom); arx_load_h = 1'($urandom);
      br_load_h = 1'($urandom); brx_load_h = 1'($urandom);
      mq_shin_lo_h = 1'($urandom); mq_shin_hi_h = 1'($urandom);
      cache_data_h = W'($urandom); sh_h = W'($urandom); vma_held_or_pc_h = W'($urandom);
      ada_sel = 2'($urandom); ada_dis_h = ($urandom_range(0, 7) == 0); adb_sel = 2'($urandom);
      ad_boole_h = 1'($urandom); ad_func = 4'($urandom); ad_cry_in_h = 1'($urandom);
      fm_block = 3'($urandom); fm_adr = 4'($urandom); fm_write_l = ($urandom_range(0, 3) != 0);
      fm_check_h = 1'($urandom); fm_err_clr_h = ($urandom_range(0, 7) == 0);
      ebus_drive_h = 1'($urandom); diag_read_h = 1'($urandom); diag_sel = 3'($urandom);
      #1;
      idx = int'(fm_block) * FM_ACS + int'(fm_adr);
      rd  = fm_d[idx];
      case (ada_sel)
        2'd0: a = m_ar;
        2'd1: a = m_arx;
        2'd2: a = m_mq;
        default: a = int'(vma_held_or_pc_h);
      endcase
      if (ada_dis_h) a = 0;
      case (adb_sel)
        2'd0: b = rd;
        2'd1: b = m_br;
        2'd2: b = m_brx;
        default: b = MASK;
      endcase
      ref_adder(a, b, ad_boole_h, int'(ad_func), ad_cry_in_h, r, cy, g, p, o);
      chk("rnd_ad", ad_h, r);         chk("rnd_cry", ad_cry_out_h, cy);
      chk("rnd_cg", ad_cg_h, g);      chk("rnd_cp", ad_cp_h, p);
      chk("rnd_ovf", ad_ovf_h, o);    chk("rnd_eq0", ad_eq0_h, r == 0);
      chk("rnd_fmpar", fm_parity_h, fm_p[idx]);
      chk("rnd_ar", ar_h, m_ar);      chk("rnd_arx", arx_h, m_arx);
      chk("rnd_br", br_h, m_br);      chk("rnd_brx", brx_h, m_brx);
      chk("rnd_mq", mq_h, m_mq);      chk("rnd_ebus", ebus_d_h, m_ebus);
      chk("rnd_err", fm_par_err_h, m_err);
      chk("rnd_shout", {mq_shout_hi_h, mq_shout_lo_h}, {((m_mq >> (W - 1)) & 1) == 1, (m_mq & 1) == 1});

      case (diag_sel)
        3'd0: dg = m_ar;  3'd1: dg = m_arx; 3'd2: dg = m_br;  3'd3: dg = m_brx;
        3'd4: dg = m_mq;  3'd5: dg = rd;    3'd6: dg = r;     default: dg = 0;
      endcase
      n_ar  = !ar_load_h ? m_ar :
              (ar_sel == 0) ? r : (ar_sel == 1) ? int'(cache_data_h) : (ar_sel == 2) ? int'(sh_h) : rd;
      n_arx = !arx_load_h ? m_arx :
              (arx_sel == 0) ? r : (arx_sel == 1) ? int'(cache_data_h) : (arx_sel == 2) ? int'(sh_h) : m_mq;
      n_br  = br_load_h ? m_ar : m_br;
      n_brx = brx_load_h ? m_arx : m_brx;
      case (mq_sel)
        2'd0: n_mq = m_mq;
        2'd1: n_mq = (mqm_sel == 0) ? r : (mqm_sel == 1) ? int'(sh_h) :
                     (mqm_sel == 2) ? int'(cache_data_h) : 0;
        2'd2: n_mq = ((m_mq << 1) | int'(mq_shin_lo_h)) & MASK;
        default: n_mq = (m_mq >> 1) | (int'(mq_shin_hi_h) << (W - 1));
      endcase
      n_ebus  = ebus_drive_h ? (diag_read_h ? dg : r) : 0;
      n_err_m = (fm_check_h && fm_p[idx] != par_of(rd)) ? 1 : (fm_err_clr_h ? 0 : m_err);
      if (!fm_write_l) begin
        fm_d[idx] = m_ar;
        fm_p[idx] = par_of(m_ar);
      end
      if (!edp_reset_l) begin
        m_ar = 0; m_arx = 0; m_br = 0; m_brx = 0; m_mq = 0; m_ebus = 0; m_err = 0;
      end else begin
        m_ar = n_ar; m_arx = n_arx; m_br = n_br; m_brx = n_brx; m_mq = n_mq;
        m_ebus = n_ebus; m_err = n_err_m;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
